// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, drives the ROM, and queues {pc, inst} pairs for ID.
// Latency: fetch issued in cycle N is at the head in N+1 (ROM_LAT=0) or N+2 (ROM_LAT=1); a flush takes one cycle.
// Backpressure: no new fetch while count + inflight reaches DEPTH; a dequeue frees a slot for the following cycle.
//
// Ports:
//   clk, rst                        single clock, synchronous active-high reset
//   rom_addr_o / rom_ce_o           fetch address (the fetch PC) and fetch-issue strobe
//   rom_data_i                      ROM read data (same cycle or next cycle, per ROM_LAT)
//   flush_i / flush_pc_i            redirect request and its target PC
//   deq_i                           ID consumes the head entry
//   valid_o / pc_o / inst_o         head entry (pc/inst forced to 0 when empty)
//   count_o                         number of queued entries
module fetch_queue #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter int                ROM_LAT  = 0,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [ADDR_W-1:0]        rom_addr_o,
    output logic                     rom_ce_o,
    input  logic [DATA_W-1:0]        rom_data_i,
    input  logic                     flush_i,
    input  logic [ADDR_W-1:0]        flush_pc_i,
    input  logic                     deq_i,
    output logic                     valid_o,
    output logic [ADDR_W-1:0]        pc_o,
    output logic [DATA_W-1:0]        inst_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0] fpc_q, fpc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
    logic [ADDR_W-1:0] mem_pc_q [DEPTH];
    logic [ADDR_W-1:0] mem_pc_d [DEPTH];
    logic [DATA_W-1:0] mem_inst_q [DEPTH];
    logic [DATA_W-1:0] mem_inst_d [DEPTH];

    logic              issue;
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] wr_pc;
    logic [CNT_W:0]    occupancy;

    // Issue / write / read strobes.
    always_comb begin
        // An in-flight fetch already owns a slot, so it counts against capacity.
        occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
        issue     = !rst && !flush_i && (occupancy < DEPTH_C);
        if (ROM_LAT == 0) begin
            wr_en = issue;
            wr_pc = fpc_q;
        end else begin
            // Returning data belongs to the fetch issued last cycle; a flush drops it.
            wr_en = inflight_q && !flush_i && !rst;
            wr_pc = inflight_pc_q;
        end
        rd_en = deq_i && (count_q != '0) && !flush_i;
    end

    // Next-state logic.
    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        fpc_d         = fpc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        mem_pc_d      = mem_pc_q;
        mem_inst_d    = mem_inst_q;

        if (wr_en) begin
            mem_pc_d[tail_q]   = wr_pc;
            mem_inst_d[tail_q] = rom_data_i;
            tail_d             = tail_q + 1'b1;
        end
        if (rd_en) begin
            head_d = head_q + 1'b1;
        end
        count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);

        if (issue) begin
            fpc_d         = fpc_q + ADDR_W'(4);
            inflight_pc_d = fpc_q;
            inflight_d    = (ROM_LAT != 0);
        end

        // Redirect wins over everything except reset.
        if (flush_i) begin
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
            inflight_d = 1'b0;
            fpc_d      = flush_pc_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            fpc_q         <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            fpc_q         <= fpc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    // Storage needs no reset: entries are only visible through a non-zero count.
    always_ff @(posedge clk) begin
        mem_pc_q   <= mem_pc_d;
        mem_inst_q <= mem_inst_d;
    end

    always_comb begin
        rom_addr_o = fpc_q;
        rom_ce_o   = issue;
        valid_o    = !rst && (count_q != '0);
        pc_o       = valid_o ? mem_pc_q[head_q] : '0;
        inst_o     = valid_o ? mem_inst_q[head_q] : '0;
        count_o    = rst ? '0 : count_q;
    end

endmodule
